id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 178 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of a 5-stage in-order core, combined with the
//   load-use hazard detector and a saturating stall-cycle counter.
//
// Parameters
//   DATA_W     width of the operand, immediate and forwarded data paths
//   STALL_SAT  ceiling at which the stall counter stops (default 16'hFFFF)
//
// Ports
//   clk_i, rst_i                   clock; asynchronous active-low reset
//   RSdata_i, RTdata_i, Imm_i      ID-side operands and sign-extended immediate
//   RSaddr_i, RTaddr_i, RDaddr_i   ID-side source/destination register numbers
//   RegWrite_i .. ALUSrc_i,
//   ALUOp_i                        decoded controls of the instruction in ID
//   Flush_i                        squash the instruction currently in ID
//   RSdata_o .. ALUOp_o            registered EX-side copies of the ID inputs
//   PCWrite_o, IFIDWrite_o         enables for PC and IF/ID (low while stalling)
//   Stall_o                        load-use stall in this cycle
//   StallCnt_o                     saturating count of stalled cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int          DATA_W    = 32,
    parameter logic [15:0] STALL_SAT = 16'hFFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [4:0]        RSaddr_i,
    input  logic [4:0]        RTaddr_i,
    input  logic [4:0]        RDaddr_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic [2:0]        ALUOp_i,
    input  logic              Flush_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [4:0]        RSaddr_o,
    output logic [4:0]        RTaddr_o,
    output logic [4:0]        RDaddr_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic [2:0]        ALUOp_o,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o,
    output logic              Stall_o,
    output logic [15:0]       StallCnt_o
);

    logic [DATA_W-1:0] rs_data_q,  rs_data_d;
    logic [DATA_W-1:0] rt_data_q,  rt_data_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [4:0]        rs_addr_q,  rs_addr_d;
    logic [4:0]        rt_addr_q,  rt_addr_d;
    logic [4:0]        rd_addr_q,  rd_addr_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              alu_src_q,  alu_src_d;
    logic [2:0]        alu_op_q,   alu_op_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic              hazard_s;
    logic              stall_s;
    logic              bubble_s;

    // Load-use detection: a load in EX whose destination feeds the ID instruction.
    // A flush wins over the stall because the dependent instruction is squashed.
    always_comb begin
        hazard_s = mem_read_q
                 & (rd_addr_q != 5'd0)
                 & ((rd_addr_q == RSaddr_i) | (rd_addr_q == RTaddr_i));
        stall_s  = hazard_s & ~Flush_i;
        bubble_s = Flush_i | stall_s;
    end

    // Next-state of the pipeline register: normal load, or a bubble whose
    // controls and destination are cleared. Data/address fields still follow
    // the inputs in a bubble since nothing downstream consumes them.
    always_comb begin
        rs_data_d = RSdata_i;
        rt_data_d = RTdata_i;
        imm_d     = Imm_i;
        rs_addr_d = RSaddr_i;
        rt_addr_d = RTaddr_i;
        if (bubble_s) begin
            rd_addr_d    = 5'd0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            alu_src_d    = 1'b0;
            alu_op_d     = 3'd0;
        end else begin
            rd_addr_d    = RDaddr_i;
            reg_write_d  = RegWrite_i;
            mem_to_reg_d = MemtoReg_i;
            mem_read_d   = MemRead_i;
            mem_write_d  = MemWrite_i;
            alu_src_d    = ALUSrc_i;
            alu_op_d     = ALUOp_i;
        end
    end

    // Saturating stall counter: holds at the ceiling instead of wrapping.
    always_comb begin
        if (stall_s && (stall_cnt_q < STALL_SAT)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_addr_q    <= 5'd0;
            rt_addr_q    <= 5'd0;
            rd_addr_q    <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= 3'd0;
            stall_cnt_q  <= 16'd0;
        end else begin
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            rd_addr_q    <= rd_addr_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Output mapping. Hazard outputs are same-cycle; reset clears MemRead,
    // which removes any stall immediately.
    always_comb begin
        RSdata_o    = rs_data_q;
        RTdata_o    = rt_data_q;
        Imm_o       = imm_q;
        RSaddr_o    = rs_addr_q;
        RTaddr_o    = rt_addr_q;
        RDaddr_o    = rd_addr_q;
        RegWrite_o  = reg_write_q;
        MemtoReg_o  = mem_to_reg_q;
        MemRead_o   = mem_read_q;
        MemWrite_o  = mem_write_q;
        ALUSrc_o    = alu_src_q;
        ALUOp_o     = alu_op_q;
        Stall_o     = stall_s;
        PCWrite_o   = ~stall_s;
        IFIDWrite_o = ~stall_s;
        StallCnt_o  = stall_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. A behavioural model of the EX-side
//   register contents and the stall counter is advanced on every clock and
//   compared against the DUT. The counter ceiling is lowered so saturation
//   is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int          DW  = 32;
    localparam logic [15:0] SAT = 16'd200;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] i_rsdata, i_rtdata, i_imm;
    logic [4:0]    i_rsa, i_rta, i_rda;
    logic          i_regw, i_mtr, i_mr, i_mw, i_asrc, i_flush;
    logic [2:0]    i_aluop;

    logic [DW-1:0] RSdata_o, RTdata_o, Imm_o;
    logic [4:0]    RSaddr_o, RTaddr_o, RDaddr_o;
    logic          RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
    logic [2:0]    ALUOp_o;
    logic          PCWrite_o, IFIDWrite_o, Stall_o;
    logic [15:0]   StallCnt_o;

    // behavioural model of EX-side state
    logic [DW-1:0] m_rsdata, m_rtdata, m_imm;
    logic [4:0]    m_rsa, m_rta, m_rda;
    logic          m_regw, m_mtr, m_mr, m_mw, m_asrc;
    logic [2:0]    m_aluop;
    int            m_cnt;
    logic          m_bubble;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.DATA_W(DW), .STALL_SAT(SAT)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .RSdata_i(i_rsdata), .RTdata_i(i_rtdata), .Imm_i(i_imm),
        .RSaddr_i(i_rsa), .RTaddr_i(i_rta), .RDaddr_i(i_rda),
        .RegWrite_i(i_regw), .MemtoReg_i(i_mtr), .MemRead_i(i_mr),
        .MemWrite_i(i_mw), .ALUSrc_i(i_asrc), .ALUOp_i(i_aluop),
        .Flush_i(i_flush),
        .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .Imm_o(Imm_o),
        .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o), .RDaddr_o(RDaddr_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
        .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .Stall_o(Stall_o),
        .StallCnt_o(StallCnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] dut_ctrl();
        return {RDaddr_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o};
    endfunction

    function automatic logic [118:0] dut_all();
        return {RSdata_o, RTdata_o, Imm_o, RSaddr_o, RTaddr_o, dut_ctrl()};
    endfunction

    function automatic logic [12:0] mdl_ctrl();
        return {m_rda, m_regw, m_mtr, m_mr, m_mw, m_asrc, m_aluop};
    endfunction

    function automatic logic [118:0] mdl_all();
        return {m_rsdata, m_rtdata, m_imm, m_rsa, m_rta, mdl_ctrl()};
    endfunction

    // A stall happens when a load in EX writes a nonzero register read in ID,
    // unless the ID instruction is being flushed.
    function automatic logic exp_stall();
        return m_mr && (m_rda != 5'd0) && ((m_rda == i_rsa) || (m_rda == i_rta)) && !i_flush;
    endfunction

    task automatic model_reset();
        m_rsdata = '0; m_rtdata = '0; m_imm = '0;
        m_rsa = 5'd0; m_rta = 5'd0; m_rda = 5'd0;
        m_regw = 1'b0; m_mtr = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_asrc = 1'b0;
        m_aluop = 3'd0; m_cnt = 0; m_bubble = 1'b0;
    endtask

    task automatic drive(input logic [4:0] rsa, input logic [4:0] rta, input logic [4:0] rda,
                         input logic regw, input logic mtr, input logic mr, input logic mw,
                         input logic asrc, input logic [2:0] aluop, input logic flush);
        i_rsdata = $urandom; i_rtdata = $urandom; i_imm = $urandom;
        i_rsa = rsa; i_rta = rta; i_rda = rda;
        i_regw = regw; i_mtr = mtr; i_mr = mr; i_mw = mw; i_asrc = asrc;
        i_aluop = aluop; i_flush = flush;
    endtask

    // One clock: advance the model by the pipeline rules, return 1 time unit after the edge.
    task automatic tick();
        logic st;
        st = exp_stall();
        @(posedge clk);
        if (i_flush || st) begin
            m_rsdata = i_rsdata; m_rtdata = i_rtdata; m_imm = i_imm;
            m_rsa = i_rsa; m_rta = i_rta;
            m_rda = 5'd0; m_regw = 1'b0; m_mtr = 1'b0; m_mr = 1'b0;
            m_mw = 1'b0; m_asrc = 1'b0; m_aluop = 3'd0; m_bubble = 1'b1;
        end else begin
            m_rsdata = i_rsdata; m_rtdata = i_rtdata; m_imm = i_imm;
            m_rsa = i_rsa; m_rta = i_rta; m_rda = i_rda;
            m_regw = i_regw; m_mtr = i_mtr; m_mr = i_mr; m_mw = i_mw;
            m_asrc = i_asrc; m_aluop = i_aluop; m_bubble = 1'b0;
        end
        if (st && (m_cnt < int'(SAT))) m_cnt = m_cnt + 1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        model_reset();
        #12;
        checks++;
        if (dut_all() !== 119'd0) begin
            failures++; $display("FAIL reset_regs got=%h exp=0", dut_all());
        end
        checks++;
        if ({Stall_o, PCWrite_o, IFIDWrite_o, StallCnt_o} !== {1'b0, 1'b1, 1'b1, 16'd0}) begin
            failures++; $display("FAIL reset_hazard got stall=%b pcw=%b ifid=%b cnt=%0d exp 0 1 1 0",
                                 Stall_o, PCWrite_o, IFIDWrite_o, StallCnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        i_rsdata = 32'h11; i_rtdata = 32'h22;
        #1;
        checks++;
        if (Stall_o !== 1'b0) begin
            failures++; $display("FAIL normal_stall got=%b exp=0", Stall_o);
        end
        tick();
        checks++;
        if ({RSdata_o, RTdata_o, RDaddr_o, RegWrite_o} !== {32'h11, 32'h22, 5'd3, 1'b1}) begin
            failures++; $display("FAIL normal_load got rs=%h rt=%h rd=%0d rw=%b exp 11 22 3 1",
                                 RSdata_o, RTdata_o, RDaddr_o, RegWrite_o);
        end
        checks++;
        if (dut_all() !== mdl_all()) begin
            failures++; $display("FAIL normal_all got=%h exp=%h", dut_all(), mdl_all());
        end
    endtask

    task automatic test_load_use();
        int cnt0;
        cnt0 = m_cnt;
        drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        drive(5'd5, 5'd9, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        #1;
        checks++;
        if ({Stall_o, PCWrite_o, IFIDWrite_o} !== 3'b100) begin
            failures++; $display("FAIL loaduse_stall got=%b%b%b exp=100", Stall_o, PCWrite_o, IFIDWrite_o);
        end
        tick();
        checks++;
        if ({RegWrite_o, MemRead_o, RDaddr_o} !== {1'b0, 1'b0, 5'd0}) begin
            failures++; $display("FAIL loaduse_bubble got rw=%b mr=%b rd=%0d exp 0 0 0",
                                 RegWrite_o, MemRead_o, RDaddr_o);
        end
        checks++;
        if ({Stall_o, PCWrite_o} !== 2'b01) begin
            failures++; $display("FAIL loaduse_clear got stall=%b pcw=%b exp 0 1", Stall_o, PCWrite_o);
        end
        tick();
        checks++;
        if (dut_all() !== mdl_all() || RDaddr_o !== 5'd6) begin
            failures++; $display("FAIL loaduse_reenter got=%h exp=%h", dut_all(), mdl_all());
        end
        checks++;
        if (int'(StallCnt_o) !== cnt0 + 1) begin
            failures++; $display("FAIL loaduse_cnt got=%0d exp=%0d", StallCnt_o, cnt0 + 1);
        end
    endtask

    task automatic test_zero_reg();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        drive(5'd4, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
        #1;
        checks++;
        if (Stall_o !== 1'b0) begin
            failures++; $display("FAIL zero_reg_stall got=%b exp=0", Stall_o);
        end
        tick();
        checks++;
        if (dut_all() !== mdl_all()) begin
            failures++; $display("FAIL zero_reg_load got=%h exp=%h", dut_all(), mdl_all());
        end
    endtask

    task automatic test_flush();
        int cnt0;
        drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        cnt0 = m_cnt;
        drive(5'd1, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
        #1;
        checks++;
        if ({Stall_o, PCWrite_o, IFIDWrite_o} !== 3'b011) begin
            failures++; $display("FAIL flush_hazard got=%b%b%b exp=011", Stall_o, PCWrite_o, IFIDWrite_o);
        end
        tick();
        checks++;
        if (dut_ctrl() !== 13'd0) begin
            failures++; $display("FAIL flush_bubble got=%h exp=0", dut_ctrl());
        end
        checks++;
        if (int'(StallCnt_o) !== cnt0) begin
            failures++; $display("FAIL flush_cnt got=%0d exp=%0d", StallCnt_o, cnt0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
            #1;
            checks++;
            if ({Stall_o, PCWrite_o, IFIDWrite_o} !== {exp_stall(), !exp_stall(), !exp_stall()}) begin
                failures++; $display("FAIL rand_stall it=%0d got=%b%b%b exp_stall=%b",
                                     n, Stall_o, PCWrite_o, IFIDWrite_o, exp_stall());
            end
            tick();
            checks++;
            if (m_bubble ? (dut_ctrl() !== mdl_ctrl()) : (dut_all() !== mdl_all())) begin
                failures++; $display("FAIL rand_regs it=%0d got=%h exp=%h", n, dut_all(), mdl_all());
            end
            checks++;
            if (int'(StallCnt_o) !== m_cnt) begin
                failures++; $display("FAIL rand_cnt it=%0d got=%0d exp=%0d", n, StallCnt_o, m_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < int'(SAT) + 4; n++) begin
            drive(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
            tick();
            drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
            tick();
        end
        checks++;
        if (StallCnt_o !== SAT || int'(StallCnt_o) !== m_cnt) begin
            failures++; $display("FAIL saturation got=%0d exp=%0d", StallCnt_o, SAT);
        end
    endtask

    task automatic test_async_reset();
        drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        drive(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        #1;
        checks++;
        if (Stall_o !== 1'b1) begin
            failures++; $display("FAIL areset_pre got=%b exp=1", Stall_o);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_all() !== 119'd0 || StallCnt_o !== 16'd0) begin
            failures++; $display("FAIL areset_regs got=%h cnt=%0d exp 0 0", dut_all(), StallCnt_o);
        end
        checks++;
        if ({Stall_o, PCWrite_o, IFIDWrite_o} !== 3'b011) begin
            failures++; $display("FAIL areset_hazard got=%b%b%b exp=011", Stall_o, PCWrite_o, IFIDWrite_o);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (dut_all() !== mdl_all() || RDaddr_o !== 5'd6) begin
            failures++; $display("FAIL areset_first_load got=%h exp=%h", dut_all(), mdl_all());
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_random();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
